// File: rtl/bus_pair_pkg.sv
// Shared types and helpers for the bus-pair FIFO: bus bounds, the stored pair
// layout, occupancy encoding and pointer wrap.
package bus_pair_pkg;

  localparam int MSB        = 2;
  localparam int LSB        = -2;
  localparam int W          = MSB - LSB + 1;
  localparam int DEF_DEPTH  = 4;
  localparam int DEF_AF_LVL = 3;
  localparam int CW         = $clog2(DEF_DEPTH + 1);
  localparam int PW         = $clog2(DEF_DEPTH);

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_PART  = 2'd1,
    OCC_FULL  = 2'd2
  } occ_state_t;

  // Each field keeps its own declared range so bit k stays bit k end to end.
  typedef struct packed {
    logic [MSB:LSB] b0;
    logic [LSB:MSB] b1;
  } pair_t;

  function automatic int unsigned ptr_inc(input int unsigned ptr, input int unsigned depth);
    return (ptr == depth - 1) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/bus_pair_mem.sv
// DEPTH-entry register array of bus pairs: one write port, one async read port.
module bus_pair_mem
  import bus_pair_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int PW_L  = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_we,
  input  logic [PW_L-1:0] i_waddr,
  input  pair_t           i_wdata,
  input  logic [PW_L-1:0] i_raddr,
  output pair_t           o_rdata
);

  pair_t r_mem [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/bus_pair_fifo.sv
// Show-ahead valid/ready FIFO carrying a descending and an ascending 5-bit bus
// side by side; occupancy is tracked as EMPTY/PART/FULL alongside the count.
module bus_pair_fifo
  import bus_pair_pkg::*;
#(
  parameter int DEPTH  = DEF_DEPTH,
  parameter int AF_LVL = DEF_AF_LVL
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [MSB:LSB]               in_b0,
  input  logic [LSB:MSB]               in_b1,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [MSB:LSB]               out_b0,
  output logic [LSB:MSB]               out_b1,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         almost_full,
  output logic                         drop,
  output occ_state_t                   dbg_state
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = $clog2(DEPTH);

  // Handshake: a pair moves on a rising edge only when valid and ready are both
  // high in the cycle before it; ready never depends on the same-cycle valid.
  occ_state_t       r_state;
  occ_state_t       w_state_nxt;
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] w_count_nxt;
  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic             r_drop;
  logic             r_af;
  logic             w_push;
  logic             w_pop;
  pair_t            w_wdata;
  pair_t            w_rdata;

  assign w_push  = in_valid & in_ready;
  assign w_pop   = out_valid & out_ready;
  assign w_wdata = '{b0: in_b0, b1: in_b1};

  bus_pair_mem #(.DEPTH(DEPTH)) u_mem (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_we    (w_push),
    .i_waddr (r_tail),
    .i_wdata (w_wdata),
    .i_raddr (r_head),
    .o_rdata (w_rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= OCC_EMPTY;
      r_count <= '0;
      r_head  <= '0;
      r_tail  <= '0;
      r_drop  <= 1'b0;
      r_af    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_count <= w_count_nxt;
      r_drop  <= in_valid & ~in_ready;
      r_af    <= (w_count_nxt >= CNT_W'(AF_LVL));
      if (w_push) r_tail <= PTR_W'(ptr_inc(32'(r_tail), unsigned'(DEPTH)));
      if (w_pop)  r_head <= PTR_W'(ptr_inc(32'(r_head), unsigned'(DEPTH)));
    end
  end

  always_comb begin
    w_count_nxt = r_count;
    if (w_push && !w_pop)      w_count_nxt = r_count + CNT_W'(1);
    else if (w_pop && !w_push) w_count_nxt = r_count - CNT_W'(1);
    if (w_count_nxt == '0)                  w_state_nxt = OCC_EMPTY;
    else if (w_count_nxt == CNT_W'(DEPTH))  w_state_nxt = OCC_FULL;
    else                                    w_state_nxt = OCC_PART;
  end

  // Non-head entries may hold stale pairs, so the bus is forced to zero when idle.
  always_comb begin
    in_ready  = (r_state != OCC_FULL);
    out_valid = (r_state != OCC_EMPTY);
    out_b0    = '0;
    out_b1    = '0;
    if (out_valid) begin
      out_b0 = w_rdata.b0;
      out_b1 = w_rdata.b1;
    end
  end

  assign count       = r_count;
  assign almost_full = r_af;
  assign drop        = r_drop;
  assign dbg_state   = r_state;

endmodule

// File: tb/tb_bus_pair_fifo.sv
// Self-checking bench for bus_pair_fifo: scoreboard queue of expected pairs,
// occupancy/flag model per cycle, directed scenarios from reset to mid-run reset.
module tb_bus_pair_fifo;
  import bus_pair_pkg::*;

  localparam int DEPTH = 4;
  localparam int AF    = 3;
  localparam int PWID  = 2 * W;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [MSB:LSB]   in_b0;
  logic [LSB:MSB]   in_b1;
  logic             out_valid;
  logic             out_ready;
  logic [MSB:LSB]   out_b0;
  logic [LSB:MSB]   out_b1;
  logic [2:0]       count;
  logic             almost_full;
  logic             drop;
  occ_state_t       dbg_state;

  logic [PWID-1:0]  exp_q[$];
  logic             exp_drop;
  int               n_tests;
  int               n_fail;
  int               n_popped;

  bus_pair_fifo #(.DEPTH(DEPTH), .AF_LVL(AF)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_b0       (in_b0),
    .in_b1       (in_b1),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_b0      (out_b0),
    .out_b1      (out_b1),
    .count       (count),
    .almost_full (almost_full),
    .drop        (drop),
    .dbg_state   (dbg_state)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // driver: called just after a falling edge; checks, clocks one edge, returns at next falling edge
  task automatic step(input logic v, input logic [PWID-1:0] data, input logic rdy);
    int              cnt;
    logic [PWID-1:0] head;
    occ_state_t      st;
    in_valid  = v;
    {in_b0, in_b1} = data;
    out_ready = rdy;
    #1;
    cnt = exp_q.size();
    st  = (cnt == 0) ? OCC_EMPTY : (cnt == DEPTH) ? OCC_FULL : OCC_PART;
    check("count",       32'(count),       32'(cnt));
    check("in_ready",    32'(in_ready),    32'(cnt != DEPTH));
    check("out_valid",   32'(out_valid),   32'(cnt != 0));
    check("almost_full", 32'(almost_full), 32'(cnt >= AF));
    check("drop",        32'(drop),        32'(exp_drop));
    check("state",       32'(dbg_state),   32'(st));
    if (cnt == 0) check("out_zero", 32'({out_b0, out_b1}), 32'(0));
    if (rdy && cnt != 0) begin
      head = exp_q.pop_front();
      check("out_data", 32'({out_b0, out_b1}), 32'(head));
      n_popped++;
    end
    if (v && cnt != DEPTH) exp_q.push_back(data);
    exp_drop = v && (cnt == DEPTH);
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    int idx;
    int base;
    logic v;
    n_tests   = 0;
    n_fail    = 0;
    n_popped  = 0;
    exp_drop  = 1'b0;
    rst_n     = 1'b0;
    in_valid  = 1'b1;
    in_b0     = 5'h1F;
    in_b1     = 5'h1F;
    out_ready = 1'b0;

    // 1 reset with producer already driving
    #6;
    check("rst_out_valid", 32'(out_valid),   32'(0));
    check("rst_in_ready",  32'(in_ready),    32'(1));
    check("rst_count",     32'(count),       32'(0));
    check("rst_out_b",     32'({out_b0, out_b1}), 32'(0));
    check("rst_af",        32'(almost_full), 32'(0));
    check("rst_drop",      32'(drop),        32'(0));
    @(negedge clk);
    rst_n    = 1'b1;
    in_valid = 1'b0;

    // 2 index fidelity across both range directions
    step(1'b1, {5'b10110, 5'b01101}, 1'b0);
    check("idx_b0_p2",  32'(out_b0[2]),  32'(1));
    check("idx_b0_m2",  32'(out_b0[-2]), 32'(0));
    check("idx_b1_m2",  32'(out_b1[-2]), 32'(0));
    check("idx_b1_p2",  32'(out_b1[2]),  32'(1));
    check("idx_b1_m1",  32'(out_b1[-1]), 32'(1));
    step(1'b0, '0, 1'b1);

    // 3 fill, then one rejected push
    for (int i = 1; i <= 4; i++) step(1'b1, {5'(i), 5'(i)}, 1'b0);
    step(1'b1, {5'd5, 5'd5}, 1'b0);
    step(1'b0, '0, 1'b0);

    // 4 pop while full does not free a slot in the same cycle
    step(1'b1, {5'd5, 5'd5}, 1'b1);
    step(1'b1, {5'd5, 5'd5}, 1'b0);
    check("full_refill", 32'(exp_q.size()), 32'(DEPTH));
    for (int i = 0; i < 8 && exp_q.size() != 0; i++) step(1'b0, '0, 1'b1);
    step(1'b0, '0, 1'b0);

    // 5 streaming with stalled consumer every other cycle; pointers wrap
    idx  = 0;
    base = n_popped;
    for (int cyc = 0; cyc < 100 && (n_popped - base) < 10; cyc++) begin
      v = (idx < 10) && (exp_q.size() != DEPTH);
      step(v, {5'(idx), 5'(idx)}, (cyc % 2) == 0);
      if (v) idx++;
    end
    check("wrap_popped", 32'(n_popped - base), 32'(10));
    step(1'b0, '0, 1'b0);

    // 6 asynchronous reset with two entries held
    step(1'b1, {5'h11, 5'h12}, 1'b0);
    step(1'b1, {5'h13, 5'h14}, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("arst_count",     32'(count),     32'(0));
    check("arst_out_valid", 32'(out_valid), 32'(0));
    check("arst_in_ready",  32'(in_ready),  32'(1));
    check("arst_out_b",     32'({out_b0, out_b1}), 32'(0));
    #4 rst_n = 1'b1;
    exp_q.delete();
    exp_drop = 1'b0;
    @(negedge clk);
    step(1'b1, {5'h0A, 5'h15}, 1'b0);
    step(1'b0, '0, 1'b1);
    step(1'b0, '0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
